// File: rtl/buffer_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// buffer_write_arbiter_pkg
//   Shared constants for the producer-to-buffer write arbiter and anything that
//   demultiplexes the tagged words on the far side of the buffer.
//   - DEF_* : default parameter values for buffer_write_arbiter
//   - DATA_WIDTH : buffer word width ({channel_id, payload}), shared with the
//                  FIFO buffer's DATA_WIDTH
//   - TAG_MSB/TAG_LSB : position of the channel tag inside a buffer word
//   - arb_state_e : arbiter FSM encoding
// -----------------------------------------------------------------------------
package buffer_write_arbiter_pkg;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_ID_WIDTH    = 2;
  localparam int DEF_REQ_WIDTH   = 30;
  localparam int DEF_STALL_LIMIT = 8;

  localparam int DATA_WIDTH = DEF_ID_WIDTH + DEF_REQ_WIDTH;

  // Channel tag sits in the MSBs of every stored word.
  localparam int TAG_LSB = DEF_REQ_WIDTH;
  localparam int TAG_MSB = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/buffer_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Scans req starting one above last_grant,
//   wrapping modulo N_REQ, and returns the first requesting channel.
//   Ports:
//     req        in  N_REQ     request vector
//     last_grant in  ID_WIDTH  most recently accepted channel
//     any_req    out 1         at least one request bit set
//     grant      out ID_WIDTH  winning channel (meaningful only when any_req)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic                any_req,
  output logic [ID_WIDTH-1:0] grant
);

  logic [ID_WIDTH-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    any_req = 1'b0;
    grant   = last_grant;
    cand    = '0;
    // Step 1..N_REQ so last_grant itself is considered last.
    for (int step = 1; step <= N_REQ; step++) begin
      cand = ID_WIDTH'((int'(last_grant) + step) % N_REQ);
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        grant   = cand;
      end
    end
  end

endmodule

// File: rtl/buffer_write_arbiter.sv
// -----------------------------------------------------------------------------
// buffer_write_arbiter
//   Round-robin scheduler sharing the FIFO buffer's single write port between
//   N_REQ producer channels. Each accepted word is tagged with its channel ID.
//   The buffer's data_in_ack is registered (valid one cycle after a strobe), so
//   every attempt is a single-cycle strobe followed by an ack-check cycle; a
//   missing ack re-issues the same word.
//   Ports:
//     clk, rst   clock (rising edge), asynchronous active-high reset
//     req_data   packed payloads, channel i at [i*REQ_WIDTH +: REQ_WIDTH]
//     req_valid  per-channel word pending (held until req_ack)
//     req_ack    one-cycle pulse: channel's word is stored
//     buf_data   {channel_id, payload} to buffer data_in
//     buf_valid  buffer data_in_valid, never high two cycles in a row
//     buf_ack    buffer data_in_ack (registered, one cycle after strobe)
//     grant_id   channel currently being served (holds in IDLE)
//     busy       FSM is not IDLE
//     stall      retries on the current word >= STALL_LIMIT (status only)
// -----------------------------------------------------------------------------
module buffer_write_arbiter
  import buffer_write_arbiter_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter int REQ_WIDTH   = DEF_REQ_WIDTH,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ*REQ_WIDTH-1:0]    req_data,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ack,
  output logic [ID_WIDTH+REQ_WIDTH-1:0] buf_data,
  output logic                          buf_valid,
  input  logic                          buf_ack,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic                          stall
);

  localparam int RETRY_WIDTH = $clog2(STALL_LIMIT + 1);
  localparam logic [RETRY_WIDTH-1:0] STALL_TH = RETRY_WIDTH'(STALL_LIMIT);

  arb_state_e                    state_q, state_d;
  logic [ID_WIDTH-1:0]           last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]           grant_id_q, grant_id_d;
  logic [ID_WIDTH+REQ_WIDTH-1:0] buf_data_q, buf_data_d;
  logic                          buf_valid_q, buf_valid_d;
  logic [N_REQ-1:0]              req_ack_q, req_ack_d;
  logic                          busy_q, busy_d;
  logic                          stall_q, stall_d;
  logic [RETRY_WIDTH-1:0]        retry_cnt_q, retry_cnt_d;

  logic                 pick_any;
  logic [ID_WIDTH-1:0]  pick_id;
  logic [REQ_WIDTH-1:0] pick_payload;

  rr_pick #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .any_req    (pick_any),
    .grant      (pick_id)
  );

  always_comb begin
    pick_payload = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_id == ID_WIDTH'(i)) pick_payload = req_data[i*REQ_WIDTH +: REQ_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    buf_data_d   = buf_data_q;
    retry_cnt_d  = retry_cnt_q;
    // Strobes and ack pulses are single-cycle: default low, raised per state.
    buf_valid_d  = 1'b0;
    req_ack_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_id_d  = pick_id;
          buf_data_d  = {pick_id, pick_payload};
          retry_cnt_d = '0;
          buf_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (buf_ack) begin
          req_ack_d[grant_id_q] = 1'b1;
          last_grant_d          = grant_id_q;
          retry_cnt_d           = '0;
          state_d               = ACK;
        end else begin
          // Buffer full or busy with a read: same word, same grant, try again.
          if (retry_cnt_q != '1) retry_cnt_d = retry_cnt_q + 1'b1;
          buf_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      // No arbitration here: the acked channel's req_valid is still stale.
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    stall_d = (retry_cnt_d >= STALL_TH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values, independent of statement order.
      state_q      <= IDLE;
      last_grant_q <= ID_WIDTH'(N_REQ - 1);
      grant_id_q   <= '0;
      buf_data_q   <= '0;
      buf_valid_q  <= 1'b0;
      req_ack_q    <= '0;
      busy_q       <= 1'b0;
      stall_q      <= 1'b0;
      retry_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      buf_data_q   <= buf_data_d;
      buf_valid_q  <= buf_valid_d;
      req_ack_q    <= req_ack_d;
      busy_q       <= busy_d;
      stall_q      <= stall_d;
      retry_cnt_q  <= retry_cnt_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign buf_data  = buf_data_q;
  assign buf_valid = buf_valid_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buffer_write_arbiter
//   Producers, a registered-ack buffer and a timeline reference model of the
//   arbiter. Outputs are compared against the model every cycle; directed
//   scenarios add literal expectations; a per-channel order scoreboard checks
//   that every offered word is stored exactly once and in order.
// -----------------------------------------------------------------------------
module tb_buffer_write_arbiter;

  localparam int N  = 4;
  localparam int PW = 30;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*PW-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ack;
  logic [DW-1:0]   buf_data;
  logic            buf_valid;
  logic            buf_ack;
  logic [1:0]      grant_id;
  logic            busy;
  logic            stall;

  buffer_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ack   (req_ack),
    .buf_data  (buf_data),
    .buf_valid (buf_valid),
    .buf_ack   (buf_ack),
    .grant_id  (grant_id),
    .busy      (busy),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- environment state ----------------
  typedef logic [PW-1:0] pay_q_t[$];
  pay_q_t        pq[N];          // words each producer still has to offer
  pay_q_t        sent[N];        // every word offered, for the order check
  logic [DW-1:0] mem[$];         // words the buffer stored
  logic [DW-1:0] strobe_log[$];
  int            strobe_cyc[$];
  int            ack_ch[$];
  int            ack_cyc[$];
  logic          stall_at_ack[$];
  int            stall_rise  = -1;
  int            consec      = 0;
  int            fail_budget = 0;
  bit            rand_mode   = 1'b0;
  logic [N-1:0]  ack_seen    = '0;
  bit            pend_ack    = 1'b0;
  bit            prev_valid  = 1'b0;
  int            cyc         = 0;

  // ---------------- reference model (timeline of the word in flight) --------
  // m_k counts cycles since the grant: odd = strobe cycle, even = ack-check.
  bit            m_active = 1'b0;
  bit            m_acked  = 1'b0;
  int            m_k      = 0;
  int            m_ch     = 0;
  int            m_fails  = 0;
  int            m_last   = N - 1;
  int            m_grant  = 0;
  logic [DW-1:0] m_word   = '0;
  int            m_win;
  bit            m_found;

  task automatic model_reset();
    m_active = 1'b0; m_acked = 1'b0; m_k = 0; m_ch = 0; m_fails = 0;
    m_last = N - 1; m_grant = 0; m_word = '0;
  endtask

  // Model advances on the edge using the inputs of the cycle that just ended.
  initial forever begin
    @(posedge clk);
    if (rst) model_reset();
    else if (!m_active) begin
      if (req_valid != '0) begin
        m_found = 1'b0;
        m_win   = 0;
        for (int j = 1; j <= N; j++) begin
          if (!m_found && req_valid[(m_last + j) % N]) begin
            m_found = 1'b1;
            m_win   = (m_last + j) % N;
          end
        end
        m_active = 1'b1; m_acked = 1'b0; m_k = 1; m_fails = 0;
        m_ch = m_win; m_grant = m_win;
        m_word = {m_win[1:0], req_data[m_win*PW +: PW]};
      end
    end else if (m_acked) begin
      m_active = 1'b0;
      m_acked  = 1'b0;
    end else begin
      if (m_k % 2 == 0) begin
        if (buf_ack) begin
          m_acked = 1'b1;
          m_last  = m_ch;
        end else if (m_fails < 15) m_fails++;
      end
      m_k++;
    end
  end

  // Producers and buffer ack, driven just after the edge.
  initial forever begin
    @(posedge clk);
    #1;
    buf_ack = rst ? 1'b0 : pend_ack;
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      req_valid[i] = (pq[i].size() > 0);
      if (pq[i].size() > 0) req_data[i*PW +: PW] = pq[i][0];
      else req_data[i*PW +: PW] = '0;
    end
  end

  // Compare process plus buffer behaviour, on the falling edge.
  logic         e_valid, e_stall;
  logic [N-1:0] e_ack;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      check("reset_outputs", 64'({buf_valid, busy, stall, req_ack, grant_id, buf_data}), 64'(0));
      model_reset();
      ack_seen   = '0;
      pend_ack   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      e_valid = m_active && !m_acked && (m_k % 2 == 1);
      e_stall = m_active && !m_acked && (m_fails >= 8);
      e_ack   = m_acked ? (4'b0001 << m_ch) : 4'b0000;
      check("buf_valid", 64'(buf_valid), 64'(e_valid));
      check("buf_data",  64'(buf_data),  64'(m_word));
      check("req_ack",   64'(req_ack),   64'(e_ack));
      check("grant_id",  64'(grant_id),  64'(m_grant));
      check("busy",      64'(busy),      64'(m_active));
      check("stall",     64'(stall),     64'(e_stall));

      if (buf_valid) begin
        strobe_log.push_back(buf_data);
        strobe_cyc.push_back(cyc);
        if (stall && stall_rise < 0) stall_rise = strobe_log.size();
        if (fail_budget > 0) begin
          fail_budget--;
          pend_ack = 1'b0;
        end else pend_ack = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (pend_ack) mem.push_back(buf_data);
      end else pend_ack = 1'b0;
      if (buf_valid && prev_valid) consec++;
      prev_valid = buf_valid;

      ack_seen = req_ack;
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          ack_ch.push_back(i);
          ack_cyc.push_back(cyc);
          stall_at_ack.push_back(stall);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [PW-1:0] p);
    pq[c].push_back(p);
    sent[c].push_back(p);
  endtask

  task automatic clear_env();
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      sent[i].delete();
    end
    mem.delete(); strobe_log.delete(); strobe_cyc.delete();
    ack_ch.delete(); ack_cyc.delete(); stall_at_ack.delete();
    stall_rise = -1; consec = 0; fail_budget = 0; rand_mode = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_env();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_acks(input int n, input int budget);
    int t = 0;
    while (ack_ch.size() < n && t < budget) begin
      tick();
      t++;
    end
    check("ack_count", 64'(ack_ch.size()), 64'(n));
  endtask

  function automatic int pending_words();
    int p = 0;
    for (int i = 0; i < N; i++) p += pq[i].size();
    if (m_active) p++;
    return p;
  endfunction

  // Every offered word stored exactly once, in offer order, per channel.
  task automatic check_order();
    for (int c = 0; c < N; c++) begin
      int k = 0;
      foreach (mem[w]) begin
        if (int'(mem[w][31:30]) == c) begin
          if (k < sent[c].size()) check("order", 64'(mem[w][29:0]), 64'(sent[c][k]));
          k++;
        end
      end
      check("write_count", 64'(k), 64'(sent[c].size()));
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int t;
    int same;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    buf_ack   = 1'b0;
    repeat (3) tick();
    check("rst_grant",    64'(grant_id),  64'(0));
    check("rst_busy",     64'(busy),      64'(0));
    check("rst_buf_data", 64'(buf_data),  64'(0));
    check("rst_req_ack",  64'(req_ack),   64'(0));
    check("rst_valid",    64'(buf_valid), 64'(0));
    rst = 1'b0;
    tick();

    // Single channel, buffer always accepts.
    do_reset();
    push(0, 30'h1234567);
    wait_acks(1, 40);
    repeat (3) tick();
    check("t1_strobes", 64'(strobe_log.size()), 64'(1));
    check("t1_data",    64'(strobe_log[0]),     64'(32'h0123_4567));
    check("t1_writes",  64'(mem.size()),        64'(1));
    check("t1_ack_ch",  64'(ack_ch[0]),         64'(0));
    check("t1_latency", 64'(ack_cyc[0] - strobe_cyc[0]), 64'(2));
    check_order();

    // All four channels continuously requesting, eight words.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) push(c, PW'($urandom()));
    wait_acks(8, 100);
    for (int k = 0; k < 8; k++) check("t2_grant_order", 64'(ack_ch[k]), 64'(k % 4));
    check("t2_back_to_back", 64'(consec), 64'(0));
    check_order();

    // Buffer full: nine rejected attempts on channel 2, then accepted.
    do_reset();
    fail_budget = 9;
    push(2, 30'h2ABCDEF0);
    t = 0;
    while (strobe_log.size() == 0 && t < 20) begin tick(); t++; end
    check("t3_first_strobe", 64'(strobe_log.size()), 64'(1));
    push(3, 30'h0000_0333);
    push(0, 30'h0000_0111);
    wait_acks(3, 200);
    same = 0;
    foreach (strobe_log[s]) if (strobe_log[s] == 32'hAABC_DEF0) same++;
    check("t3_identical_strobes", 64'(same), 64'(10));
    check("t3_total_strobes", 64'(strobe_log.size()), 64'(12));
    check("t3_stall_rise_strobe", 64'(stall_rise), 64'(9));
    check("t3_stall_at_ack", 64'(stall_at_ack[0]), 64'(0));
    check("t3_ack0", 64'(ack_ch[0]), 64'(2));
    check("t3_next_grant", 64'(ack_ch[1]), 64'(3));
    check("t3_ack2", 64'(ack_ch[2]), 64'(0));
    check_order();

    // One missed ack (read had priority): second strobe, single write.
    do_reset();
    fail_budget = 1;
    push(1, 30'h0F0F0F0);
    wait_acks(1, 40);
    repeat (2) tick();
    check("t4_strobes", 64'(strobe_log.size()), 64'(2));
    check("t4_writes",  64'(mem.size()),        64'(1));
    check("t4_word",    64'(mem[0]),            64'(32'h40F0_F0F0));
    check("t4_latency", 64'(ack_cyc[0] - strobe_cyc[0]), 64'(4));

    // Asynchronous reset while waiting for the ack.
    do_reset();
    fail_budget = 1000;
    push(2, 30'h15555555);
    t = 0;
    while (strobe_log.size() == 0 && t < 20) begin tick(); t++; end
    check("t5_strobe", 64'(strobe_log.size()), 64'(1));
    @(posedge clk);
    #2;
    check("t5_busy_before", 64'({busy, grant_id}), 64'({1'b1, 2'd2}));
    rst = 1'b1;
    #1;
    check("t5_async_reset", 64'({buf_valid, busy, stall, req_ack, grant_id, buf_data}), 64'(0));
    clear_env();
    push(0, 30'h0000_0A00);
    push(3, 30'h0000_0A03);
    tick();
    tick();
    rst = 1'b0;
    wait_acks(2, 40);
    check("t5_first_after_reset", 64'(ack_ch[0]), 64'(0));
    check("t5_second", 64'(ack_ch[1]), 64'(3));
    check_order();

    // Channel 1 offers a new word right after its ack.
    do_reset();
    push(1, 30'h0000AAA);
    push(1, 30'h0000555);
    wait_acks(2, 40);
    repeat (2) tick();
    check("t6_writes",  64'(mem.size()),        64'(2));
    check("t6_first",   64'(mem[0]),            64'(32'h4000_0AAA));
    check("t6_second",  64'(mem[1]),            64'(32'h4000_0555));
    check("t6_strobes", 64'(strobe_log.size()), 64'(2));
    check("t6_spacing", 64'(ack_cyc[1] - ack_cyc[0]), 64'(4));

    // Randomized traffic with random buffer back-pressure.
    do_reset();
    rand_mode = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 7) == 0 && pq[c].size() < 3) push(c, PW'($urandom()));
      tick();
    end
    t = 0;
    while (pending_words() > 0 && t < 4000) begin tick(); t++; end
    repeat (2) tick();
    check("rand_drained", 64'(pending_words()), 64'(0));
    check("rand_back_to_back", 64'(consec), 64'(0));
    check_order();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
